dcache_sram_wr_ctrl: RTL and testbench

Write-port controller that sits directly upstream of the data-cache way SRAM (512 x 32, byte-enabled, simple dual-port). It merges two write sources onto the single SRAM write port: critical-word-first line refills from the memory side, and CPU store hits with byte enables. It sequences each refill (request handshake, beat collection, address wrap) and blocks stores that would race with an in-flight fill of the same line.

---
 rtl/dcache_sram_wr_ctrl_if.sv | 61 ++++++
 rtl/dcache_sram_wr_ctrl.sv | 154 +++++++++++++++
 tb/tb_dcache_sram_wr_ctrl.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_sram_wr_ctrl_if.sv
// Bus bundle for the data-cache SRAM write-port controller: refill control,
// memory read request/response, CPU store port and SRAM write port.
//
// Handshakes: a transfer happens on a clock edge where valid and ready are
// both 1. The controller keeps mem_req_valid asserted with a stable
// index/crit until mem_req_ready is seen. mem_rready is level-high for the
// whole fill because the SRAM never stalls. st_ready is a combinational
// function of the current inputs and does not depend on st_valid.
interface dcache_sram_wr_ctrl_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = 4,
  parameter int OFFS_WIDTH = 3,
  parameter int IDX_WIDTH  = 6
);
  logic                  refill_req;
  logic [IDX_WIDTH-1:0]  refill_index;
  logic [OFFS_WIDTH-1:0] refill_crit;
  logic                  refill_busy;
  logic                  refill_done;
  logic                  refill_err;
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [IDX_WIDTH-1:0]  mem_req_index;
  logic [OFFS_WIDTH-1:0] mem_req_crit;
  logic                  mem_rvalid;
  logic                  mem_rready;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_rlast;
  logic                  st_valid;
  logic                  st_ready;
  logic [ADDR_WIDTH-1:0] st_addr;
  logic [DATA_WIDTH-1:0] st_data;
  logic [BE_WIDTH-1:0]   st_be;
  logic                  sram_wr_en;
  logic [ADDR_WIDTH-1:0] sram_wr_addr;
  logic [DATA_WIDTH-1:0] sram_wr_data;
  logic [BE_WIDTH-1:0]   sram_wr_byte_en;

  // Controller side
  modport slave (
    input  refill_req, refill_index, refill_crit,
    input  mem_req_ready, mem_rvalid, mem_rdata, mem_rlast,
    input  st_valid, st_addr, st_data, st_be,
    output refill_busy, refill_done, refill_err,
    output mem_req_valid, mem_req_index, mem_req_crit, mem_rready,
    output st_ready,
    output sram_wr_en, sram_wr_addr, sram_wr_data, sram_wr_byte_en
  );

  // Environment side (cache control, memory, CPU, SRAM)
  modport master (
    output refill_req, refill_index, refill_crit,
    output mem_req_ready, mem_rvalid, mem_rdata, mem_rlast,
    output st_valid, st_addr, st_data, st_be,
    input  refill_busy, refill_done, refill_err,
    input  mem_req_valid, mem_req_index, mem_req_crit, mem_rready,
    input  st_ready,
    input  sram_wr_en, sram_wr_addr, sram_wr_data, sram_wr_byte_en
  );
endinterface

// File: rtl/dcache_sram_wr_ctrl.sv
// Data-cache SRAM write-port controller. Merges critical-word-first line
// refills and CPU store hits onto the single SRAM write port. Refill beats
// always win; stores to the line being filled are held off until the fill
// has finished so they cannot be overwritten by stale memory data.
module dcache_sram_wr_ctrl #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = 4,
  parameter int OFFS_WIDTH = 3,
  parameter int IDX_WIDTH  = 6
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  dcache_sram_wr_ctrl_if.slave   bus,
  output logic [1:0]             state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_FILL = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [IDX_WIDTH-1:0]  idx_q, idx_d;
  logic [OFFS_WIDTH-1:0] crit_q, crit_d;
  logic [OFFS_WIDTH-1:0] cnt_q, cnt_d;

  logic                  err_q;
  logic                  wr_en_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic [BE_WIDTH-1:0]   wr_be_q;

  logic                  beat_acc;
  logic                  last_beat;
  logic [OFFS_WIDTH-1:0] beat_offs;
  logic [IDX_WIDTH-1:0]  st_line;
  logic                  hazard;
  logic                  st_acc;

  // A beat is taken whenever memory offers one during FILL (rready is high).
  assign beat_acc  = (state_q == S_FILL) && bus.mem_rvalid;
  assign last_beat = (cnt_q == {OFFS_WIDTH{1'b1}});
  // Offset wraps naturally within the line because of the truncated width.
  assign beat_offs = crit_q + cnt_q;
  assign st_line   = bus.st_addr[ADDR_WIDTH-1:OFFS_WIDTH];

  // Line hazard: the store targets the line in flight, or the line that is
  // being requested this very cycle.
  assign hazard = ((state_q != S_IDLE) && (st_line == idx_q)) ||
                  ((state_q == S_IDLE) && bus.refill_req && (st_line == bus.refill_index));

  assign bus.st_ready = !beat_acc && !hazard;
  assign st_acc       = bus.st_valid && bus.st_ready;

  assign state_o = state_q;

  // State register with synchronous reset; a reset mid-refill aborts it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      crit_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      crit_q  <= crit_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: request, collect eight beats, one-cycle done.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    crit_d  = crit_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.refill_req) begin
          idx_d   = bus.refill_index;
          crit_d  = bus.refill_crit;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.mem_req_ready) begin
          cnt_d   = '0;
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        if (bus.mem_rvalid) begin
          cnt_d = cnt_q + 1'b1;
          if (last_beat) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from the current state.
  always_comb begin
    bus.refill_busy   = (state_q != S_IDLE);
    bus.refill_done   = (state_q == S_DONE);
    bus.mem_req_valid = (state_q == S_REQ);
    bus.mem_rready    = (state_q == S_FILL);
    bus.mem_req_index = idx_q;
    bus.mem_req_crit  = crit_q;
  end

  // Registered SRAM write port and rlast error pulse; beats beat stores.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_be_q   <= '0;
    end else begin
      err_q <= beat_acc && (bus.mem_rlast != last_beat);
      if (beat_acc) begin
        wr_en_q   <= 1'b1;
        wr_addr_q <= {idx_q, beat_offs};
        wr_data_q <= bus.mem_rdata;
        wr_be_q   <= {BE_WIDTH{1'b1}};
      end else if (st_acc) begin
        wr_en_q   <= 1'b1;
        wr_addr_q <= bus.st_addr;
        wr_data_q <= bus.st_data;
        wr_be_q   <= bus.st_be;
      end else begin
        wr_en_q   <= 1'b0;
      end
    end
  end

  assign bus.refill_err      = err_q;
  assign bus.sram_wr_en      = wr_en_q;
  assign bus.sram_wr_addr    = wr_addr_q;
  assign bus.sram_wr_data    = wr_data_q;
  assign bus.sram_wr_byte_en = wr_be_q;

endmodule

// File: tb/tb_dcache_sram_wr_ctrl.sv
// Bench for the data-cache SRAM write-port controller. Inputs change on the
// falling edge; registered outputs are observed 2 time units after the
// rising edge. Expected SRAM writes are queued as {addr, data, be}.
module tb_dcache_sram_wr_ctrl;

  logic       clk;
  logic       rst;
  logic [1:0] dut_state;

  dcache_sram_wr_ctrl_if bus ();

  dcache_sram_wr_ctrl dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .bus     (bus),
    .state_o (dut_state)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0;
  int n_err = 0;
  int done_seen = 0;
  int err_seen = 0;

  logic [44:0] exp_q[$];
  logic [31:0] ref_mem[512];
  logic [31:0] sram_mem[512];
  int          touched[$];
  logic [8:0]  last_addr;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Scoreboard push: expected write plus reference memory image.
  task automatic push_wr(input logic [8:0] a, input logic [31:0] d, input logic [3:0] be);
    exp_q.push_back({a, d, be});
    for (int b = 0; b < 4; b++) begin
      if (be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
    end
    touched.push_back(int'(a));
    last_addr = a;
  endtask

  // Monitor: every SRAM write must match the head of the expected queue.
  always @(posedge clk) begin
    logic [44:0] got;
    logic [44:0] exp;
    #2;
    if (bus.sram_wr_en) begin
      got = {bus.sram_wr_addr, bus.sram_wr_data, bus.sram_wr_byte_en};
      if (exp_q.size() == 0) begin
        check("unexp_wr", 64'(bus.sram_wr_en), 64'd0);
      end else begin
        exp = exp_q.pop_front();
        check("sram_wr", 64'(got), 64'(exp));
      end
      for (int b = 0; b < 4; b++) begin
        if (bus.sram_wr_byte_en[b]) sram_mem[bus.sram_wr_addr][8*b +: 8] = bus.sram_wr_data[8*b +: 8];
      end
    end
    if (bus.refill_done) done_seen++;
    if (bus.refill_err) err_seen++;
  end

  // Driver tasks
  task automatic step();
    @(negedge clk);
    bus.refill_req    = 1'b0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rvalid    = 1'b0;
    bus.mem_rlast     = 1'b0;
    bus.st_valid      = 1'b0;
  endtask

  function automatic logic [8:0] pick(input int pa, input int pb, input logic [5:0] idx);
    logic [5:0] line;
    if (pa >= 0 && pb >= 0) return ($urandom_range(0, 1) != 0) ? 9'(pa) : 9'(pb);
    if (pa >= 0) return 9'(pa);
    line = ($urandom_range(0, 1) != 0) ? idx : 6'($urandom_range(0, 63));
    return {line, 3'($urandom_range(0, 7))};
  endfunction

  // Offer a store this cycle and check st_ready against the expected rule.
  task automatic probe(input logic [8:0] a, input logic ok_exp);
    logic [31:0] d;
    logic [3:0]  be;
    d  = $urandom;
    be = 4'($urandom_range(0, 15));
    bus.st_valid = 1'b1;
    bus.st_addr  = a;
    bus.st_data  = d;
    bus.st_be    = be;
    #1;
    check("st_ready", 64'(bus.st_ready), 64'(ok_exp));
    if (ok_exp) push_wr(a, d, be);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_wr_en"},    64'(bus.sram_wr_en), 0);
    check({tag, "_wr_addr"},  64'(bus.sram_wr_addr), 0);
    check({tag, "_wr_data"},  64'(bus.sram_wr_data), 0);
    check({tag, "_wr_be"},    64'(bus.sram_wr_byte_en), 0);
    check({tag, "_busy"},     64'(bus.refill_busy), 0);
    check({tag, "_done"},     64'(bus.refill_done), 0);
    check({tag, "_err"},      64'(bus.refill_err), 0);
    check({tag, "_req_v"},    64'(bus.mem_req_valid), 0);
    check({tag, "_req_idx"},  64'(bus.mem_req_index), 0);
    check({tag, "_req_crit"}, 64'(bus.mem_req_crit), 0);
    check({tag, "_rready"},   64'(bus.mem_rready), 0);
    check({tag, "_state"},    64'(dut_state), 0);
  endtask

  // One full refill transaction. Called on a falling edge with the DUT idle.
  task automatic do_refill(input logic [5:0] idx, input logic [2:0] crit, input logic [7:0] rlast_pat,
                           input int abort_after, input bit ramp_data,
                           input int pa, input int pb, input int gap_min);
    int          done0, err0, exp_err;
    logic [8:0]  a;
    logic [31:0] d;
    logic [2:0]  off;
    done0 = done_seen;
    err0 = err_seen;
    exp_err = 0;

    // Request cycle: a store to the requested line is already blocked.
    bus.refill_req   = 1'b1;
    bus.refill_index = idx;
    bus.refill_crit  = crit;
    if ($urandom_range(0, 1) != 0) begin
      a = pick(pa, pb, idx);
      probe(a, a[8:3] != idx);
    end
    step();

    // Request phase; extra refill_req attempts must be ignored.
    repeat ($urandom_range(0, 2)) begin
      check("req_valid", 64'(bus.mem_req_valid), 1);
      check("req_index", 64'(bus.mem_req_index), 64'(idx));
      check("req_crit",  64'(bus.mem_req_crit), 64'(crit));
      check("busy_req",  64'(bus.refill_busy), 1);
      bus.refill_req   = 1'b1;
      bus.refill_index = ~idx;
      bus.refill_crit  = ~crit;
      if ($urandom_range(0, 1) != 0) begin
        a = pick(pa, pb, idx);
        probe(a, a[8:3] != idx);
      end
      step();
    end
    check("req_valid", 64'(bus.mem_req_valid), 1);
    check("req_index", 64'(bus.mem_req_index), 64'(idx));
    check("rready_req", 64'(bus.mem_rready), 0);
    bus.mem_req_ready = 1'b1;
    step();

    for (int k = 0; k < 8; k++) begin
      repeat ($urandom_range(gap_min, gap_min + 1)) begin
        check("rready_gap", 64'(bus.mem_rready), 1);
        check("req_valid_fill", 64'(bus.mem_req_valid), 0);
        if ($urandom_range(0, 3) != 0) begin
          a = pick(pa, pb, idx);
          probe(a, a[8:3] != idx);
        end
        step();
      end
      check("rready_beat", 64'(bus.mem_rready), 1);
      d = ramp_data ? (32'hFFFF_FFFF - 32'(k)) : $urandom;
      off = 3'(int'(crit) + k);
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = d;
      bus.mem_rlast  = rlast_pat[k];
      push_wr({idx, off}, d, 4'hF);
      if (rlast_pat[k] != (k == 7)) exp_err++;
      if ($urandom_range(0, 1) != 0) probe(pick(pa, pb, idx), 1'b0);
      step();

      if (abort_after == k + 1) begin
        rst = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = $urandom;
        step();
        check_zero("abort");
        rst = 1'b0;
        repeat (2) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = $urandom;
          #1;
          check("abort_rready", 64'(bus.mem_rready), 0);
          step();
        end
        check("abort_done_cnt", 64'(done_seen - done0), 0);
        check("abort_err_cnt", 64'(err_seen - err0), 64'(exp_err));
        return;
      end
    end

    // DONE cycle coincides with the last beat's SRAM write.
    check("done_pulse", 64'(bus.refill_done), 1);
    check("busy_done",  64'(bus.refill_busy), 1);
    check("wr_en_last", 64'(bus.sram_wr_en), 1);
    probe({idx, 3'($urandom_range(0, 7))}, 1'b0);
    step();
    check("done_clear", 64'(bus.refill_done), 0);
    check("busy_clear", 64'(bus.refill_busy), 0);
    check("wr_en_idle", 64'(bus.sram_wr_en), 0);
    check("wr_addr_hold", 64'(bus.sram_wr_addr), 64'(last_addr));
    check("done_cnt", 64'(done_seen - done0), 1);
    check("err_cnt",  64'(err_seen - err0), 64'(exp_err));
  endtask

  // Stimulus and final report
  initial begin
    for (int i = 0; i < 512; i++) begin
      ref_mem[i]  = '0;
      sram_mem[i] = '0;
    end
    last_addr = '0;
    rst = 1'b1;
    bus.refill_req = 1'b0;
    bus.refill_index = '0;
    bus.refill_crit = '0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata = '0;
    bus.mem_rlast = 1'b0;
    bus.st_valid = 1'b0;
    bus.st_addr = '0;
    bus.st_data = '0;
    bus.st_be = '0;
    step();
    step();
    check_zero("reset");
    rst = 1'b0;
    step();

    // Line 5 from word 0 with a descending data ramp: addresses 40..47.
    do_refill(6'd5, 3'd0, 8'h80, 0, 1'b1, -1, -1, 0);
    // Line 3 from word 5: addresses 29,30,31,24..28.
    do_refill(6'd3, 3'd5, 8'h80, 0, 1'b0, -1, -1, 0);
    // Store to addr 100 (other line): taken on gaps, refused on beats.
    do_refill(6'd7, 3'd2, 8'h80, 0, 1'b0, 100, -1, 1);
    // Line 12 in flight: addr 97 always refused, addr 0 taken on gaps.
    do_refill(6'd12, 3'd4, 8'h80, 0, 1'b0, 97, 0, 1);
    // rlast early on beat 4 and missing on beat 8: two error pulses.
    do_refill(6'd9, 3'd1, 8'h08, 0, 1'b0, -1, -1, 0);
    // Reset after beat 3, then the same line refilled normally.
    do_refill(6'd20, 3'd6, 8'h00, 3, 1'b0, -1, -1, 0);
    do_refill(6'd20, 3'd6, 8'h80, 0, 1'b0, -1, -1, 0);
    // Random back-to-back refills with occasional rlast errors.
    for (int r = 0; r < 6; r++) begin
      do_refill(6'($urandom_range(0, 63)), 3'($urandom_range(0, 7)),
                ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h80,
                0, 1'b0, -1, -1, 0);
    end

    step();
    step();
    check("exp_q_empty", 64'(exp_q.size()), 0);
    foreach (touched[i]) begin
      check("readback", 64'(sram_mem[touched[i]]), 64'(ref_mem[touched[i]]));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
